// File: rtl/mux_16x1_if.sv
// mux_16x1_if: signal bundle for the 16:1 single-bit multiplexer.
//   in     data word, bit i is mux input i
//   sel    select index, unsigned binary
//   en     capture enable for the registered path
//   y      combinational output = in[sel]
//   y_q    registered output
//   y_vld  y_q holds a captured value since the last reset
// master: the side that drives data/select (producer or testbench).
// slave : the multiplexer itself.
interface mux_16x1_if #(
  parameter int N_IN = 16
) ();
  localparam int SEL_W = $clog2(N_IN);

  logic [N_IN-1:0]  in;
  logic [SEL_W-1:0] sel;
  logic             en;
  logic             y;
  logic             y_q;
  logic             y_vld;

  modport master (
    output in, sel, en,
    input  y, y_q, y_vld
  );

  modport slave (
    input  in, sel, en,
    output y, y_q, y_vld
  );
endinterface

// File: rtl/mux_16x1.sv
// mux_16x1: N_IN:1 single-bit multiplexer with a combinational output and a
// registered copy qualified by a valid flag.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears y_q and y_vld immediately
//   bus    mux_16x1_if slave modport (in, sel, en -> y, y_q, y_vld)
module mux_16x1 #(
  parameter int N_IN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_16x1_if.slave  bus
);
  localparam int SEL_W = $clog2(N_IN);

  logic [N_IN-1:0]  data;
  logic [SEL_W-1:0] idx;
  logic             y_comb;
  logic             cap_q, cap_d;
  logic             vld_q, vld_d;

  assign data = bus.in;
  assign idx  = bus.sel;

  // Plain variable index: an X/Z select yields X in simulation, and
  // unselected bits never reach the output.
  assign y_comb = data[idx];

  always_comb begin
    cap_d = cap_q;
    vld_d = vld_q;
    if (bus.en) begin
      cap_d = y_comb;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      cap_q <= cap_d;
      vld_q <= vld_d;
    end
  end

  assign bus.y     = y_comb;
  assign bus.y_q   = cap_q;
  assign bus.y_vld = vld_q;
endmodule

// File: tb/tb_mux_16x1.sv
module tb_mux_16x1;
  typedef struct {
    int    which;   // 0: y, 1: y_q, 2: y_vld
    logic  exp;
    string name;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb_q[$];
  int   n_vec;
  int   n_bad;

  mux_16x1_if #(.N_IN(16)) bus ();

  mux_16x1 #(.N_IN(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: whenever an expectation is posted, the outputs have settled;
  // pop and compare against the live DUT output.
  initial begin
    exp_t e;
    logic act;
    n_vec = 0;
    n_bad = 0;
    forever begin
      wait (sb_q.size() != 0);
      e = sb_q.pop_front();
      case (e.which)
        0:       act = bus.y;
        1:       act = bus.y_q;
        default: act = bus.y_vld;
      endcase
      n_vec++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %b, expected %b (t=%0t)", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic post(input int which, input logic exp, input string name);
    exp_t e;
    e.which = which;
    e.exp   = exp;
    e.name  = name;
    sb_q.push_back(e);
  endtask

  task automatic comb_vec(input logic [15:0] d, input logic [3:0] s,
                          input logic exp, input string name);
    bus.in  = d;
    bus.sel = s;
    #1;
    post(0, exp, name);
    #1;
  endtask

  task automatic check_regs(input logic exp_q, input logic exp_v, input string name);
    post(1, exp_q, {name, ".y_q"});
    post(2, exp_v, {name, ".y_vld"});
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat;
    rst_n   = 1'b1;
    bus.en  = 1'b0;
    bus.in  = 16'h0000;
    bus.sel = 4'd0;

    // Reset before any clock edge (first posedge at t=5).
    #2 rst_n = 1'b0;
    #1 check_regs(1'b0, 1'b0, "reset_no_edge");

    // Combinational path during reset, with en active.
    bus.en = 1'b1;
    comb_vec(16'h674F, 4'd5,  1'b0, "674F_sel5");
    comb_vec(16'h674F, 4'd12, 1'b0, "674F_sel12");
    comb_vec(16'h674F, 4'd8,  1'b1, "674F_sel8");
    comb_vec(16'hA017, 4'd0,  1'b1, "A017_sel0");
    comb_vec(16'hA017, 4'd5,  1'b0, "A017_sel5");
    comb_vec(16'hA017, 4'd3,  1'b0, "A017_sel3");
    comb_vec(16'hA017, 4'd10, 1'b0, "A017_sel10");
    comb_vec(16'hA017, 4'd15, 1'b1, "A017_sel15");

    // Walking one and walking zero across every select.
    for (int k = 0; k < 16; k++) begin
      for (int s = 0; s < 16; s++) begin
        pat = 16'h0001 << k;
        comb_vec(pat, 4'(s), (s == k), $sformatf("walk1_k%0d_s%0d", k, s));
        comb_vec(~pat, 4'(s), (s != k), $sformatf("walk0_k%0d_s%0d", k, s));
      end
    end

    // Registers stay cleared across edges while reset is held.
    bus.in  = 16'hFFFF;
    bus.sel = 4'd3;
    @(posedge clk); #1;
    check_regs(1'b0, 1'b0, "held_in_reset");

    // Release and first capture.
    @(negedge clk);
    rst_n   = 1'b1;
    bus.en  = 1'b1;
    bus.in  = 16'h674F;
    bus.sel = 4'd8;
    @(posedge clk); #1;
    check_regs(1'b1, 1'b1, "first_capture");

    // Hold with en=0 while y follows sel immediately.
    @(negedge clk);
    bus.en = 1'b0;
    comb_vec(16'h674F, 4'd5, 1'b0, "hold_y_sel5");
    check_regs(1'b1, 1'b1, "hold_pre_edge");
    @(posedge clk); #1;
    check_regs(1'b1, 1'b1, "hold_post_edge");

    // Capture a 0, then a 1 again.
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk); #1;
    check_regs(1'b0, 1'b1, "capture_zero");
    @(negedge clk);
    bus.sel = 4'd8;
    @(posedge clk); #1;
    check_regs(1'b1, 1'b1, "capture_one");

    // Mid-run reset pulse between edges.
    @(negedge clk);
    bus.en = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_regs(1'b0, 1'b0, "midrun_reset");
    comb_vec(16'hA017, 4'd15, 1'b1, "reset_y_sel15");
    comb_vec(16'hA017, 4'd3,  1'b0, "reset_y_sel3");
    rst_n = 1'b1;

    // After release with en=0 nothing is captured.
    @(posedge clk); #1;
    check_regs(1'b0, 1'b0, "post_reset_en0");
    @(negedge clk);
    bus.en  = 1'b1;
    bus.sel = 4'd0;
    @(posedge clk); #1;
    check_regs(1'b1, 1'b1, "post_reset_capture");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) #1;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
